// File: rtl/uart_rx_pkg.sv
// Shared constants for the UART RX front stage: legal oversampling ratios,
// the frame length and the idle line level.
package uart_rx_pkg;

  localparam int   PRESCALE_8     = 8;
  localparam int   PRESCALE_16    = 16;
  localparam int   PRESCALE_32    = 32;
  localparam int   FRAME_BITS_MAX = 11;
  localparam logic RX_IDLE        = 1'b1;

  function automatic logic prescale_legal(input int unsigned p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler_if.sv
// Bundle between the RX FSM (master) and the bit sampler (slave):
// line input, prescale, enables, and the counter/sample outputs.
interface uart_rx_bit_sampler_if #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  cnt_en;
  logic                  samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  sample_valid;
  logic                  bit_done;

  modport master (
    output rx_in, prescale, cnt_en, samp_en,
    input  edge_cnt, bit_cnt, sampled_bit, sample_valid, bit_done
  );

  modport slave (
    input  rx_in, prescale, cnt_en, samp_en,
    output edge_cnt, bit_cnt, sampled_bit, sample_valid, bit_done
  );
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for the serial line; both stages reset to the idle
// level so a reset never looks like a start bit.
module uart_rx_sync2
  import uart_rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic ff1_q;
  logic ff2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff1_q <= RX_IDLE;
      ff2_q <= RX_IDLE;
    end else begin
      ff1_q <= d_i;
      ff2_q <= ff1_q;
    end
  end

  assign q_o = ff2_q;

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART RX bit sampler: edge/bit counters plus 3-sample mid-bit majority vote.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchroniser on rx_in.
module uart_rx_bit_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_bit_sampler_if.slave   bus
);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.rx_in),
    .q_o (rx_s)
  );
`else
  assign rx_s = bus.rx_in;
`endif

  logic                  cnt_en_q, cnt_en_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic                  arm0_q, arm0_d;
  logic                  arm1_q, arm1_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  bit_done_q, bit_done_d;

  logic [PRESCALE_W-1:0] p_last, mid, mid_m1, mid_p1;
  logic                  vote;

  assign p_last = p_q - PRESCALE_W'(1);
  assign mid    = p_q >> 1;
  assign mid_m1 = mid - PRESCALE_W'(1);
  assign mid_p1 = mid + PRESCALE_W'(1);
  assign vote   = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  // p_q is stale on the cnt_en rising edge, but edge_cnt_q is 0 there so
  // none of the wrap/capture compares can fire on that edge.
  always_comb begin
    cnt_en_d       = bus.cnt_en;
    p_d            = p_q;
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    s0_d           = s0_q;
    s1_d           = s1_q;
    arm0_d         = arm0_q;
    arm1_d         = arm1_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    bit_done_d     = 1'b0;

    if (!bus.cnt_en) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
      arm0_d     = 1'b0;
      arm1_d     = 1'b0;
    end else begin
      if (!cnt_en_q) begin
        p_d = prescale_legal(32'(bus.prescale)) ? bus.prescale
                                                : PRESCALE_W'(PRESCALE_8);
      end

      if (edge_cnt_q == p_last) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
        bit_done_d = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end

      // arm0/arm1 record that every capture of this bit happened with samp_en
      if (edge_cnt_q == mid_m1) begin
        arm0_d = bus.samp_en;
        if (bus.samp_en) s0_d = rx_s;
      end
      if (edge_cnt_q == mid) begin
        arm1_d = bus.samp_en & arm0_q;
        if (bus.samp_en) s1_d = rx_s;
      end
      if ((edge_cnt_q == mid_p1) && bus.samp_en && arm1_q) begin
        sampled_bit_d  = vote;
        sample_valid_d = 1'b1;
        arm0_d         = 1'b0;
        arm1_d         = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_en_q       <= 1'b0;
      p_q            <= PRESCALE_W'(PRESCALE_8);
      edge_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      s0_q           <= RX_IDLE;
      s1_q           <= RX_IDLE;
      arm0_q         <= 1'b0;
      arm1_q         <= 1'b0;
      sampled_bit_q  <= RX_IDLE;
      sample_valid_q <= 1'b0;
      bit_done_q     <= 1'b0;
    end else begin
      cnt_en_q       <= cnt_en_d;
      p_q            <= p_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      arm0_q         <= arm0_d;
      arm1_q         <= arm1_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      bit_done_q     <= bit_done_d;
    end
  end

  assign bus.edge_cnt     = edge_cnt_q;
  assign bus.bit_cnt      = bit_cnt_q;
  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.bit_done     = bit_done_q;

endmodule

// File: doc/uart_rx_bit_sampler.md
Name: uart_rx_bit_sampler

Overview:
- UART RX front stage, directly upstream of the parity checker and deserializer.
- Counts oversampling edges and bit positions for the RX FSM.
- Takes three samples of rx_in around mid-bit and majority-votes them into sampled_bit, qualified by a one-cycle sample_valid strobe.
- Consumers (deserializer, parity check, stop/start check) take sampled_bit on sample_valid.

Parameters:
- PRESCALE_W, 6, width of prescale input; supports oversampling ratios 8/16/32.
- BIT_CNT_W, 4, width of the bit counter; covers start + 8 data + parity + stop.

Ports:
- clk  input  1  RX clock (oversampling clock).
- rst  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line; idle high.
- prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- cnt_en  input  1  from RX FSM; 1 = frame in progress, 0 = clear counters.
- samp_en  input  1  from RX FSM; enables sample capture and vote.
- edge_cnt  output  PRESCALE_W  edge position within current bit, 0..P-1.
- bit_cnt  output  BIT_CNT_W  bit index within frame.
- sampled_bit  output  1  majority-voted bit value.
- sample_valid  output  1  one-cycle strobe; sampled_bit updated this cycle.
- bit_done  output  1  one-cycle strobe; bit period just completed.

Behaviour:
- Reset (rst=0, async): edge_cnt=0, bit_cnt=0, sampled_bit=1, sample_valid=0, bit_done=0, internal P=8, sample regs=1.
- P latch: effective prescale P is latched on the clk edge where cnt_en is sampled 1 while previously 0.
  - prescale not in {8,16,32} latches P=8.
  - prescale changes mid-frame are ignored.
- Mid-point: m = P/2 (4, 8, 16).
- cnt_en=0: edge_cnt and bit_cnt go to 0 next edge; sample_valid and bit_done stay 0; sampled_bit holds its value.
- cnt_en=1 edge counter: edge_cnt increments every clk.
  - At edge_cnt==P-1 it wraps to 0 and bit_cnt increments.
  - bit_done is registered high for the cycle in which edge_cnt==0 following the wrap.
- bit_cnt wraps 2^BIT_CNT_W-1 -> 0; the FSM is responsible for ending the frame earlier.
- Sampling (cnt_en=1, samp_en=1):
  - s0 <= rx on the edge where edge_cnt==m-1.
  - s1 <= rx on the edge where edge_cnt==m.
  - On the edge where edge_cnt==m+1: sampled_bit <= majority(s0, s1, rx), and sample_valid=1 for exactly that following cycle (edge_cnt==m+2).
- samp_en=0: no captures, no sample_valid; sampled_bit holds.
- samp_en dropping between captures abandons the vote; no strobe for that bit.
- Simultaneous cnt_en 1->0 on a wrap or vote edge: clear wins; no bit_done or sample_valid is issued.
- Reset mid-frame returns all state to reset values immediately.
- "rx" means rx_in, or the synchronised rx_in when the optional feature is enabled.

Optional Feature:
- Macro: UART_RX_SYNC_EN.
- Defined: rx_in passes through a 2-flop synchroniser (reset value 1) before sampling, adding 2 cycles of latency from rx_in to the sample regs.
- Undefined: rx_in is sampled directly; the FSM/top level guarantees rx_in is already synchronous.

Decomposition:
- Package uart_rx_pkg holds:
  - constants PRESCALE_8=8, PRESCALE_16=16, PRESCALE_32=32;
  - FRAME_BITS_MAX=11;
  - RX_IDLE=1'b1.
- One natural sub-module: uart_rx_sync2 (2-flop synchroniser), instantiated only under UART_RX_SYNC_EN.
- Majority vote stays inline.

Test Plan:
- Prescale 8 basics: prescale=8, cnt_en=1, samp_en=1, rx_in held 0 →
  - sample_valid pulses when edge_cnt==6, with sampled_bit=0;
  - bit_done pulses when edge_cnt==0 after 8 cycles;
  - bit_cnt reaches 1.
- Glitch rejection: prescale=16, rx=1 except a single-cycle 0 at edge_cnt==8 → sampled_bit=1. Two-cycle 0 at edge_cnt 7..8 → sampled_bit=0.
- Illegal prescale: prescale=12 at cnt_en rise → behaves as P=8 (wrap at 7, vote strobe at edge 6). Changing prescale to 32 mid-frame → no effect until the next cnt_en rise.
- Bit index count: prescale=32, 11 bits of 0x55 frame pattern → bit_cnt steps 0..10, 11 bit_done pulses, vote strobes at edge_cnt==18, sampled_bit sequence matches the pattern.
- Clear collision: cnt_en dropped on the same edge as edge_cnt==P-1 → next cycle edge_cnt=0, bit_cnt=0, bit_done=0. Async rst asserted mid-bit → all outputs at reset values without a clock.
- Sync latency (UART_RX_SYNC_EN defined): rx_in transition observed in the vote exactly 2 cycles later than in the undefined build, for identical stimulus.
